// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable synchronized lock,
// then releases the downstream domain; retries on timeout and faults after repeated failures.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 20,
  parameter int unsigned LOCK_STABLE  = 1000,
  parameter int unsigned LOCK_TIMEOUT = 10000,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  input  logic       clr_loss,
  output logic       pll_rst,
  output logic       domain_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] loss_cnt,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic          r_lock_m;
  logic          r_lock_s;
  state_t        r_state;
  logic [RW-1:0] r_rst_cnt;
  logic [SW-1:0] r_stab_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0]    r_retry;
  logic [7:0]    r_loss;
  logic          r_pll_rst;
  logic          r_domain_rst;
  logic          r_ready;
  logic          r_fault;

  state_t     w_nxt;
  logic       w_loss;
  logic       w_timeout;
  logic [3:0] w_retry_inc;
  logic       w_in_lock_phase;
  logic       w_nxt_lock_phase;

  assign w_retry_inc      = r_retry + 4'd1;
  assign w_in_lock_phase  = (r_state == S_WAIT_LOCK) || (r_state == S_STABLE);
  assign w_nxt_lock_phase = (w_nxt == S_WAIT_LOCK) || (w_nxt == S_STABLE);

  // Timeout outranks both lock progress and release; restart outranks everything.
  always_comb begin
    w_nxt     = r_state;
    w_loss    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_PLL_RST: if (r_rst_cnt == RST_LAST) w_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK, S_STABLE: begin
        if (r_to_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_nxt     = (w_retry_inc == RETRY_MAX) ? S_FAULT : S_PLL_RST;
        end else if (r_state == S_WAIT_LOCK) begin
          if (r_lock_s) w_nxt = S_STABLE;
        end else if (!r_lock_s) begin
          w_nxt = S_WAIT_LOCK;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_nxt = S_RUN;
        end
      end
      S_RUN: if (!r_lock_s) begin
        w_loss = 1'b1;
        w_nxt  = S_PLL_RST;
      end
      S_FAULT: w_nxt = S_FAULT;
      default: w_nxt = S_PLL_RST;
    endcase
    if (restart) w_nxt = S_PLL_RST;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_m     <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= S_PLL_RST;
      r_rst_cnt    <= '0;
      r_stab_cnt   <= '0;
      r_to_cnt     <= '0;
      r_retry      <= '0;
      r_loss       <= '0;
      r_pll_rst    <= 1'b1;
      r_domain_rst <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_lock_m <= locked;
      r_lock_s <= r_lock_m;
      r_state  <= w_nxt;

      // Outputs decode the next state so they change together with state.
      r_pll_rst    <= (w_nxt == S_PLL_RST) || (w_nxt == S_FAULT);
      r_domain_rst <= (w_nxt != S_RUN);
      r_ready      <= (w_nxt == S_RUN);
      r_fault      <= (w_nxt == S_FAULT);

      r_rst_cnt  <= (r_state == S_PLL_RST && w_nxt == S_PLL_RST && !restart) ? r_rst_cnt + 1'b1 : '0;
      r_stab_cnt <= (r_state == S_STABLE && w_nxt == S_STABLE) ? r_stab_cnt + 1'b1 : '0;
      r_to_cnt   <= (w_in_lock_phase && w_nxt_lock_phase) ? r_to_cnt + 1'b1 : '0;

      if (restart || w_nxt == S_RUN) r_retry <= '0;
      else if (w_timeout)            r_retry <= w_retry_inc;

      if (clr_loss)                      r_loss <= '0;
      else if (w_loss && r_loss != '1)   r_loss <= r_loss + 8'd1;
    end
  end

  assign pll_rst    = r_pll_rst;
  assign domain_rst = r_domain_rst;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign state      = r_state;
  assign loss_cnt   = r_loss;
  assign retry_cnt  = r_retry;

endmodule
